// File: rtl/alu_issue.sv
// alu_issue: operand issue and writeback stage wrapped around an external 8-bit ALU,
// with a 4 x 8-bit register file, compare flag and WB-to-issue bypass.
module alu_issue (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [7:0] alu_rd,
    output logic [7:0] alu_rs,
    output logic [3:0] alu_ctrl,
    input  logic [7:0] alu_out,
    output logic       done,
    output logic       illegal,
    output logic       flag,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state, state_nx;
    logic [7:0] regs [4];
    logic [3:0] op, imm, ctrl_nx;
    logic [1:0] rd;
    logic [7:0] res, src_rd, src_rs;
    logic       accept, wb_wr;
    logic [3:0] in_op;
    logic [1:0] in_rd, in_rs;

    assign in_op       = instr[7:4];
    assign in_rd       = instr[3:2];
    assign in_rs       = instr[1:0];
    assign instr_ready = state != EXEC;
    assign accept      = instr_valid && instr_ready;
    assign done        = state == WB;
    assign illegal     = done && op > 4'd10;
    assign wb_wr       = done && (op < 4'd8 || op == 4'd9 || op == 4'd10);
    assign dbg_data    = regs[dbg_sel];

    always_comb begin
        state_nx = state;
        state_nx = state == EXEC ? WB : (accept ? EXEC : IDLE);
        // An operand read in WB must see the result that is only being written this edge
        src_rd   = wb_wr && in_rd == rd ? res : regs[in_rd];
        src_rs   = wb_wr && in_rs == rd ? res : regs[in_rs];
        ctrl_nx  = in_op == 4'd0 ? 4'd0 : in_op < 4'd9 ? in_op - 4'd1 : 4'hF;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_rd   <= 8'h00;
            alu_rs   <= 8'h00;
            alu_ctrl <= 4'hF;
            op       <= 4'd0;
            rd       <= 2'd0;
            imm      <= 4'd0;
            res      <= 8'h00;
            flag     <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs[i] <= 8'h00;
        end else begin
            if (accept) begin
                op       <= in_op;
                rd       <= in_rd;
                imm      <= instr[3:0];
                alu_ctrl <= ctrl_nx;
                alu_rd   <= in_op == 4'd0 ? 8'h00 : src_rd;
                alu_rs   <= src_rs;
            end
            // ldil/ldih merge the immediate into the old rd value latched in alu_rd
            if (state == EXEC)
                res <= op == 4'd9 ? {alu_rd[7:4], imm} : op == 4'd10 ? {imm, alu_rd[3:0]} : alu_out;
            if (wb_wr)
                regs[rd] <= res;
            if (done && op == 4'd8)
                flag <= res[0];
        end
    end
endmodule
